mem_bus_arbiter: RTL

- Shares one single-port main-memory bus between two cache controllers, A and B.
- Each cache issues read or write requests on its own req/ack port. The arbiter serialises them with round-robin priority and forwards one transaction at a time to memory.
- It waits for the memory's completion pulse, then returns read data and a one-cycle ack to the owning cache.
- A watchdog aborts any transaction the memory never completes.

---
 rtl/mem_bus_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter that shares a single-port memory bus between
// cache controllers A and B, with a per-transaction watchdog abort.
module mem_bus_arbiter #(
  parameter int ADDRESSBIT = 16,
  parameter int WORDSIZE   = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqA,
  input  logic                  rdwtA,
  input  logic [ADDRESSBIT-1:0] addrA,
  input  logic [WORDSIZE-1:0]   dataInA,
  output logic                  ackA,
  output logic                  errA,
  output logic [WORDSIZE-1:0]   dataOutA,
  input  logic                  reqB,
  input  logic                  rdwtB,
  input  logic [ADDRESSBIT-1:0] addrB,
  input  logic [WORDSIZE-1:0]   dataInB,
  output logic                  ackB,
  output logic                  errB,
  output logic [WORDSIZE-1:0]   dataOutB,
  output logic                  mem_en,
  output logic                  mem_rdwt,
  output logic [ADDRESSBIT-1:0] mem_addr,
  output logic [WORDSIZE-1:0]   mem_wdata,
  input  logic [WORDSIZE-1:0]   mem_rdata,
  input  logic                  mem_ready
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic           ptrB;      // 1 = B has priority on the next simultaneous request
  logic           ownerB;
  logic [WDW-1:0] watchdog;
  logic           grantB;

  // B wins when it is alone, or when both ask and the pointer favours B.
  assign grantB = reqB && (!reqA || ptrB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptrB      <= 1'b0;
      ownerB    <= 1'b0;
      watchdog  <= '0;
      ackA      <= 1'b0;
      errA      <= 1'b0;
      dataOutA  <= '0;
      ackB      <= 1'b0;
      errB      <= 1'b0;
      dataOutB  <= '0;
      mem_en    <= 1'b0;
      mem_rdwt  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ackA <= 1'b0;
      errA <= 1'b0;
      ackB <= 1'b0;
      errB <= 1'b0;
      case (state)
        IDLE: begin
          if (reqA || reqB) begin
            ownerB    <= grantB;
            ptrB      <= !grantB;
            mem_rdwt  <= grantB ? rdwtB : rdwtA;
            mem_addr  <= grantB ? addrB : addrA;
            mem_wdata <= grantB ? dataInB : dataInA;
            watchdog  <= '0;
            mem_en    <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Completion takes precedence over a coincident watchdog expiry.
          if (mem_ready) begin
            if (!mem_rdwt) begin
              if (ownerB) dataOutB <= mem_rdata;
              else        dataOutA <= mem_rdata;
            end
            ackA   <= !ownerB;
            ackB   <= ownerB;
            mem_en <= 1'b0;
            state  <= DONE;
          end else if (watchdog == WDW'(TIMEOUT - 1)) begin
            ackA   <= !ownerB;
            errA   <= !ownerB;
            ackB   <= ownerB;
            errB   <= ownerB;
            mem_en <= 1'b0;
            state  <= DONE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          mem_en <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
